if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 RESET_PC, 16'h0000, PC value loaded on reset.
REQ-002 NOP_INSTR, 16'h0800, bubble instruction driven on ifo_instr when no valid fetch is presented.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ifi_branch  input  1  redirect request from decode stage.
REQ-006 ifi_new_pc  input  16  redirect target, valid when ifi_branch=1.
REQ-007 ifi_pause  input  1  stall request; holds fetch output register and PC.
REQ-008 ifo_mem_req  output  1  instruction memory read request.
REQ-009 ifo_mem_addr  output  16  instruction memory read address.
REQ-010 ifi_mem_ack  input  1  memory returns ifi_mem_data this cycle.
REQ-011 ifi_mem_data  input  16  fetched instruction word.
REQ-012 ifo_addr  output  16  address of presented instruction.
REQ-013 ifo_instr  output  16  presented instruction (IF/ID register).
REQ-014 ifo_valid  output  1  ifo_instr is a real fetch, not a bubble.

Function
REQ-015 The block SHALL implement states REQ (fetch outstanding) and HOLD (fetched word buffered during stall).
REQ-016 In REQ, ifo_mem_req SHALL be 1 and ifo_mem_addr SHALL equal PC, held stable until ack or redirect.
REQ-017 In REQ with ifi_mem_ack=1 and ifi_pause=0, at the edge the block SHALL load ifo_instr=ifi_mem_data, ifo_addr=PC, ifo_valid=1, PC=PC+1; state stays REQ.
REQ-018 Fetch latency SHALL be one cycle: ack at edge N yields ifo_valid=1 after edge N.
REQ-019 In REQ with ifi_mem_ack=0 and ifi_pause=0, the block SHALL load ifo_instr=NOP_INSTR, ifo_valid=0, PC unchanged.
REQ-020 With ifi_pause=1, ifo_addr/ifo_instr/ifo_valid and PC SHALL hold; ifi_branch SHALL be ignored.
REQ-021 In REQ with ifi_mem_ack=1 and ifi_pause=1, the block SHALL capture ifi_mem_data into a holding buffer and go to HOLD.
REQ-022 In HOLD, ifo_mem_req SHALL be 0; on first cycle with ifi_pause=0 the buffer SHALL be presented (valid=1), PC=PC+1, state REQ.
REQ-023 With ifi_branch=1 and ifi_pause=0, PC SHALL load ifi_new_pc, any outstanding request SHALL be abandoned (ack in that cycle discarded for PC increment), state REQ.
REQ-024 PC arithmetic SHALL be 16-bit modulo: 16'hFFFF+1 = 16'h0000.
REQ-025 Branch in HOLD with ifi_pause=0: redirect SHALL win; buffer discarded per REQ-029/030.

Reset
REQ-026 On rst=1 at an edge: PC=RESET_PC, state REQ, ifo_instr=NOP_INSTR, ifo_addr=16'h0000, ifo_valid=0, buffer cleared.
REQ-027 While rst=1, ifo_mem_req SHALL be 0; reset mid-fetch SHALL discard the outstanding request and any ack.
REQ-028 First request SHALL issue in the cycle after rst deasserts, at RESET_PC.

Configuration
REQ-029 Macro BRANCH_DELAY_SLOT_EN defined: the word acked in the redirect cycle (or buffered in HOLD) SHALL be presented as valid delay-slot instruction.
REQ-030 BRANCH_DELAY_SLOT_EN undefined: that word SHALL be replaced by NOP_INSTR with ifo_valid=0 (flush).

Verification
REQ-031 Reset, ack every cycle -> ifo_addr 0000,0001,0002 consecutive, ifo_valid=1 from cycle after first ack.
REQ-032 PC=16'hFFFF acked -> next ifo_mem_addr 16'h0000.
REQ-033 Ack with ifi_pause=1 for 3 cycles, data 16'h4A05 -> ifo_* frozen, mem_req=0, then 16'h4A05 presented one cycle after pause drops.
REQ-034 ifi_branch=1, ifi_new_pc=16'h0040 with ack of 16'h6801 -> next mem_addr 16'h0040; 16'h6801 valid with macro, NOP 16'h0800 valid=0 without.
REQ-035 ack held low 4 cycles -> ifo_instr=16'h0800, ifo_valid=0, ifo_mem_addr unchanged throughout.
REQ-036 rst asserted mid-fetch with simultaneous ack -> PC=RESET_PC, ifo_valid=0, acked word never presented.

Source files
------------

// File: rtl/if_stage_if.sv
// if_stage_if: fetch-stage bus (decode redirect/stall, instruction memory, IF/ID outputs)
interface if_stage_if;
  logic        ifi_branch;
  logic [15:0] ifi_new_pc;
  logic        ifi_pause;
  logic        ifo_mem_req;
  logic [15:0] ifo_mem_addr;
  logic        ifi_mem_ack;
  logic [15:0] ifi_mem_data;
  logic [15:0] ifo_addr;
  logic [15:0] ifo_instr;
  logic        ifo_valid;
  modport slave (
    input  ifi_branch, ifi_new_pc, ifi_pause, ifi_mem_ack, ifi_mem_data,
    output ifo_mem_req, ifo_mem_addr, ifo_addr, ifo_instr, ifo_valid
  );
  modport master (
    output ifi_branch, ifi_new_pc, ifi_pause, ifi_mem_ack, ifi_mem_data,
    input  ifo_mem_req, ifo_mem_addr, ifo_addr, ifo_instr, ifo_valid
  );
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction fetch with stall buffer and redirect; BRANCH_DELAY_SLOT_EN keeps the redirect-cycle word as a delay slot
module if_stage (
  input logic      clk,
  input logic      rst,
  if_stage_if.slave bus
);
  localparam logic [15:0] RESET_PC  = 16'h0000;
  localparam logic [15:0] NOP_INSTR = 16'h0800;
  typedef enum logic {REQ, HOLD} state_t;
  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_buf;
  logic [15:0] r_addr;
  logic [15:0] r_instr;
  logic        r_valid;
  logic [15:0] w_slot;
  logic        w_has;
  logic        w_keep;
  assign w_slot = (r_state == HOLD) ? r_buf : bus.ifi_mem_data;
  assign w_has  = (r_state == HOLD) || bus.ifi_mem_ack;
`ifdef BRANCH_DELAY_SLOT_EN
  assign w_keep = w_has;
`else
  assign w_keep = 1'b0;
`endif
  assign bus.ifo_mem_req  = !rst && (r_state == REQ);
  assign bus.ifo_mem_addr = r_pc;
  assign bus.ifo_addr     = r_addr;
  assign bus.ifo_instr    = r_instr;
  assign bus.ifo_valid    = r_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= REQ;
      r_pc    <= RESET_PC;
      r_buf   <= '0;
      r_addr  <= '0;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (bus.ifi_pause) begin
      if (r_state == REQ && bus.ifi_mem_ack) begin
        r_buf   <= bus.ifi_mem_data;
        r_state <= HOLD;
      end
    end else if (bus.ifi_branch) begin
      r_state <= REQ;
      r_pc    <= bus.ifi_new_pc;
      r_addr  <= r_pc;
      r_instr <= w_keep ? w_slot : NOP_INSTR;
      r_valid <= w_keep;
    end else if (w_has) begin
      r_state <= REQ;
      r_addr  <= r_pc;
      r_instr <= w_slot;
      r_valid <= 1'b1;
      r_pc    <= r_pc + 16'd1;
    end else begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed scoreboard bench for if_stage
module tb_if_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int fails = 0;
  logic [31:0] sb[$];
  logic pz = 1'b0;
  logic rz = 1'b1;
  if_stage_if bus ();
  if_stage dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, a, e, $time);
    end
  endtask
  task automatic step(input logic ack, input logic [15:0] d, input logic p, input logic br, input logic [15:0] np);
    bus.ifi_mem_ack  = ack;
    bus.ifi_mem_data = d;
    bus.ifi_pause    = p;
    bus.ifi_branch   = br;
    bus.ifi_new_pc   = np;
    @(posedge clk);
    #1;
  endtask
  always @(posedge clk) begin
    pz = bus.ifi_pause;
    rz = rst;
  end
  always @(negedge clk) begin
    if (!rz) begin
      if (bus.ifo_valid && !pz) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_valid got addr=%h instr=%h exp none", bus.ifo_addr, bus.ifo_instr);
        end else begin
          logic [31:0] e;
          e = sb.pop_front();
          chk("sb_addr", {16'h0, bus.ifo_addr}, {16'h0, e[31:16]});
          chk("sb_instr", {16'h0, bus.ifo_instr}, {16'h0, e[15:0]});
        end
      end else if (!bus.ifo_valid) begin
        chk("bubble_instr", {16'h0, bus.ifo_instr}, 32'h0800);
      end
    end
  end
  initial begin
    step(0, 16'h0, 0, 0, 16'h0);
    step(1, 16'hBEEF, 0, 0, 16'h0);
    chk("rst_mem_req", bus.ifo_mem_req, 0);
    chk("rst_valid", bus.ifo_valid, 0);
    chk("rst_instr", bus.ifo_instr, 32'h0800);
    chk("rst_addr", bus.ifo_addr, 0);
    rst = 1'b0;
    #1;
    chk("first_req", bus.ifo_mem_req, 1);
    chk("first_addr", bus.ifo_mem_addr, 0);
    for (int i = 0; i < 3; i++) begin
      sb.push_back({16'(i), 16'hA000 + 16'(i)});
      step(1, 16'hA000 + 16'(i), 0, 0, 16'h0);
      chk("seq_mem_addr", bus.ifo_mem_addr, 32'(i + 1));
      chk("seq_valid", bus.ifo_valid, 1);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 16'h1234, 0, 0, 16'h0);
      chk("noack_mem_addr", bus.ifo_mem_addr, 3);
      chk("noack_valid", bus.ifo_valid, 0);
    end
    sb.push_back({16'h0003, 16'h4003});
    step(1, 16'h4003, 0, 0, 16'h0);
    step(1, 16'h4A05, 1, 0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      chk("pause_mem_req", bus.ifo_mem_req, 0);
      chk("pause_addr", bus.ifo_addr, 3);
      chk("pause_instr", bus.ifo_instr, 32'h4003);
      chk("pause_valid", bus.ifo_valid, 1);
      if (i < 2) step(0, 16'h0, 1, 0, 16'h0);
    end
    sb.push_back({16'h0004, 16'h4A05});
    step(0, 16'h0, 0, 0, 16'h0);
    chk("unhold_valid", bus.ifo_valid, 1);
    chk("unhold_mem_addr", bus.ifo_mem_addr, 5);
    chk("unhold_mem_req", bus.ifo_mem_req, 1);
`ifdef BRANCH_DELAY_SLOT_EN
    sb.push_back({16'h0005, 16'h6801});
    step(1, 16'h6801, 0, 1, 16'h0040);
    chk("br_valid", bus.ifo_valid, 1);
`else
    step(1, 16'h6801, 0, 1, 16'h0040);
    chk("br_valid", bus.ifo_valid, 0);
`endif
    chk("br_mem_addr", bus.ifo_mem_addr, 32'h0040);
    step(0, 16'h0, 1, 1, 16'h1234);
    chk("br_paused_ignored", bus.ifo_mem_addr, 32'h0040);
    step(0, 16'h0, 0, 1, 16'hFFFF);
    chk("wrap_pre", bus.ifo_mem_addr, 32'hFFFF);
    sb.push_back({16'hFFFF, 16'h7777});
    step(1, 16'h7777, 0, 0, 16'h0);
    chk("wrap_mem_addr", bus.ifo_mem_addr, 0);
    step(1, 16'h5555, 1, 0, 16'h0);
    chk("hold_mem_req", bus.ifo_mem_req, 0);
`ifdef BRANCH_DELAY_SLOT_EN
    sb.push_back({16'h0000, 16'h5555});
    step(0, 16'h0, 0, 1, 16'h0080);
    chk("hold_br_valid", bus.ifo_valid, 1);
`else
    step(0, 16'h0, 0, 1, 16'h0080);
    chk("hold_br_valid", bus.ifo_valid, 0);
`endif
    chk("hold_br_mem_addr", bus.ifo_mem_addr, 32'h0080);
    chk("hold_br_mem_req", bus.ifo_mem_req, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_req", bus.ifo_mem_req, 0);
    step(1, 16'hDEAD, 0, 0, 16'h0);
    chk("rst_mid_valid", bus.ifo_valid, 0);
    chk("rst_mid_instr", bus.ifo_instr, 32'h0800);
    chk("rst_mid_pc", bus.ifo_mem_addr, 0);
    rst = 1'b0;
    #1;
    chk("rst_mid_req_after", bus.ifo_mem_req, 1);
    sb.push_back({16'h0000, 16'h1111});
    step(1, 16'h1111, 0, 0, 16'h0);
    step(0, 16'h0, 0, 0, 16'h0);
    @(negedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
